bus_irq_controller: RTL and testbench

- Parametrised interrupt controller mapped on the shared 8-bit CPU data bus.
- Collects up to 8 peripheral interrupt sources into one CPU raise/ack pair. Sources include the mouse, timer, IR and future peripherals.
- Each source has a pending bit, a mask bit and an edge/level mode. Lowest-index source has highest fixed priority.
- The serviced source index is readable over the bus. Generalises the fixed two-line raise/ack wiring of the top level to N channels.

---
 rtl/bus_irq_controller_if.sv | 37 +++
 rtl/bus_irq_controller.sv | 213 +++++++++++++++++++++
 tb/tb_bus_irq_controller.sv | 238 +++++++++++++++++++++++
 3 files changed

// File: rtl/bus_irq_controller_if.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bus_irq_controller_if
//  Purpose  : Bundles the bus address/strobe and the interrupt handshake
//             signals of bus_irq_controller.
//  Signals  : bus_addr  - bus address
//             bus_we    - bus write enable
//             src_in    - per-source interrupt requests (NUM_SRC wide)
//             src_ack   - per-source one-cycle acknowledge pulses
//             irq_raise - interrupt request to the CPU
//             irq_ack   - CPU acknowledge
//  Modports : slave  - the controller
//             master - CPU / peripherals / testbench side
//  Revision : 1.0 - initial release
// ============================================================================
interface bus_irq_controller_if #(
    parameter int NUM_SRC = 4
);
    logic [7:0]         bus_addr;
    logic               bus_we;
    logic [NUM_SRC-1:0] src_in;
    logic [NUM_SRC-1:0] src_ack;
    logic               irq_raise;
    logic               irq_ack;

    modport slave (
        input  bus_addr, bus_we, src_in, irq_ack,
        output src_ack, irq_raise
    );

    modport master (
        output bus_addr, bus_we, src_in, irq_ack,
        input  src_ack, irq_raise
    );
endinterface
`default_nettype wire

// File: rtl/bus_irq_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : bus_irq_controller
//  Purpose  : Bus-mapped interrupt controller. Collects up to 8 sources into a
//             single CPU raise/ack pair with per-source pending, mask and
//             edge/level mode bits; lowest index has highest priority.
//             Registers at BASE_ADDR+0..3: PENDING (W1C), MASK, VECTOR (RO),
//             MODE (1 = rising edge, 0 = level).
//  Ports    : clk_i        - system clock, rising edge
//             rst_ni       - asynchronous active-low reset
//             bus_data_io  - shared 8-bit tristate data bus; driven only in
//                            the cycle after a read of this block
//             bus_if       - slave modport: bus_addr, bus_we, src_in,
//                            irq_ack (in); src_ack, irq_raise (out)
//  Options  : BUS_IRQ_SYNC_EN - when defined, each src_in bit goes through a
//             2-flop synchroniser (edge-to-raise latency 4 cycles instead of 2)
//  Revision : 1.0 - initial release
// ============================================================================
module bus_irq_controller #(
    parameter logic [7:0] BASE_ADDR  = 8'hE0,
    parameter int         NUM_SRC    = 4,
    parameter logic [7:0] MASK_RESET = 8'h00
) (
    input  wire logic             clk_i,
    input  wire logic             rst_ni,
    inout  wire       [7:0]       bus_data_io,
    bus_irq_controller_if.slave   bus_if
);

    // Bits at or above NUM_SRC are forced to zero in every register.
    localparam logic [7:0] VALID_BITS = 8'hFF >> (8 - NUM_SRC);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_RAISED = 2'd1,
        S_GAP    = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] pend_q,   pend_d;
    logic [7:0] mask_q,   mask_d;
    logic [7:0] mode_q,   mode_d;
    logic [7:0] vector_q, vector_d;
    logic [7:0] ack_q,    ack_d;
    logic [7:0] rdata_q,  rdata_d;
    logic       oe_q,     oe_d;
    logic [7:0] src_prev_q;

    logic [7:0] src_raw;
    logic [7:0] src_s;
    logic [7:0] offset;
    logic       in_range;
    logic       wr_en;
    logic       rd_en;
    logic [7:0] wdata;
    logic [7:0] active;
    logic [2:0] win_idx;
    logic [7:0] win_oh;
    logic       take_ack;

    // Widen the source vector to the full 8-bit register width.
    always_comb begin
        src_raw                = '0;
        src_raw[NUM_SRC-1:0]   = bus_if.src_in;
    end

`ifdef BUS_IRQ_SYNC_EN
    logic [7:0] sync1_q;
    logic [7:0] sync2_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= src_raw;
            sync2_q <= sync1_q;
        end
    end

    assign src_s = sync2_q;
`else
    assign src_s = src_raw;
`endif

    // Subtracting the base makes the range check wrap-safe for any BASE_ADDR.
    assign offset   = bus_if.bus_addr - BASE_ADDR;
    assign in_range = (offset[7:2] == 6'd0);
    assign wr_en    = in_range &  bus_if.bus_we;
    assign rd_en    = in_range & ~bus_if.bus_we;
    assign wdata    = bus_data_io;

    assign active = pend_q & mask_q;

    // Fixed priority: scan from the top so the lowest set index wins.
    always_comb begin
        win_idx = 3'd0;
        for (int i = 7; i >= 0; i--) begin
            if (active[i]) begin
                win_idx = 3'(i);
            end
        end
        win_oh = 8'b1 << win_idx;
    end

    // ------------------------------------------------------------------
    // FSM: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        take_ack = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (active != 8'h00) begin
                    state_d = S_RAISED;
                end
            end
            S_RAISED: begin
                // Losing all active sources takes precedence over a
                // simultaneous ack: there is nothing left to service.
                if (active == 8'h00) begin
                    state_d = S_IDLE;
                end else if (bus_if.irq_ack) begin
                    take_ack = 1'b1;
                    state_d  = S_GAP;
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Register file and read path: next values
    // ------------------------------------------------------------------
    always_comb begin
        logic [7:0] w1c;
        logic [7:0] ack_clr;
        logic [7:0] rise;

        w1c      = (wr_en && offset[1:0] == 2'd0) ? wdata : 8'h00;
        ack_clr  = (take_ack) ? (win_oh & mode_q) : 8'h00;
        rise     = src_s & ~src_prev_q;

        // Edge bits: hold/clear, then OR in the new edge so a set beats a
        // simultaneous clear. Level bits simply follow the source.
        pend_d   = ((mode_q & ((pend_q & ~w1c & ~ack_clr) | rise))
                   | (~mode_q & src_s)) & VALID_BITS;

        mask_d   = mask_q;
        mode_d   = mode_q;
        if (wr_en && offset[1:0] == 2'd1) begin
            mask_d = wdata & VALID_BITS;
        end
        if (wr_en && offset[1:0] == 2'd3) begin
            mode_d = wdata & VALID_BITS;
        end

        vector_d = vector_q;
        ack_d    = 8'h00;
        if (take_ack) begin
            vector_d = {1'b1, 4'b0000, win_idx};
            ack_d    = win_oh & VALID_BITS;
        end

        case (offset[1:0])
            2'd0:    rdata_d = pend_q;
            2'd1:    rdata_d = mask_q;
            2'd2:    rdata_d = vector_q;
            default: rdata_d = mode_q;
        endcase
        if (!rd_en) begin
            rdata_d = 8'h00;
        end
        oe_d = rd_en;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= S_IDLE;
            pend_q     <= 8'h00;
            mask_q     <= MASK_RESET & VALID_BITS;
            mode_q     <= VALID_BITS;
            vector_q   <= 8'h00;
            ack_q      <= 8'h00;
            rdata_q    <= 8'h00;
            oe_q       <= 1'b0;
            src_prev_q <= 8'h00;
        end else begin
            state_q    <= state_d;
            pend_q     <= pend_d;
            mask_q     <= mask_d;
            mode_q     <= mode_d;
            vector_q   <= vector_d;
            ack_q      <= ack_d;
            rdata_q    <= rdata_d;
            oe_q       <= oe_d;
            src_prev_q <= src_s;
        end
    end

    // Raise is decoded from the state register so reset drops it at once.
    assign bus_if.irq_raise = (state_q == S_RAISED);
    assign bus_if.src_ack   = ack_q[NUM_SRC-1:0];
    assign bus_data_io      = oe_q ? rdata_q : 8'hzz;

endmodule
`default_nettype wire

// File: tb/tb_bus_irq_controller.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_bus_irq_controller
//  Purpose  : Directed self-checking bench for bus_irq_controller
//             (BASE_ADDR=8'hE0, NUM_SRC=4, MASK_RESET=8'h00). The data bus
//             is pulled up, so an undriven bus reads 8'hFF.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_bus_irq_controller;

    localparam logic [7:0] BASE = 8'hE0;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic [7:0] drv    = 8'h00;
    logic       drv_en = 1'b0;
    logic [7:0] rd;
    tri1  [7:0] bus_data;

    int total = 0;
    int bad   = 0;

    assign bus_data = drv_en ? drv : 8'hzz;

    bus_irq_controller_if #(.NUM_SRC(4)) bif ();

    bus_irq_controller #(
        .BASE_ADDR  (BASE),
        .NUM_SRC    (4),
        .MASK_RESET (8'h00)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .bus_data_io (bus_data),
        .bus_if      (bif)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_wr(input logic [7:0] a, input logic [7:0] d);
        bif.bus_addr = a;
        bif.bus_we   = 1'b1;
        drv          = d;
        drv_en       = 1'b1;
        step();
        bif.bus_we   = 1'b0;
        drv_en       = 1'b0;
        bif.bus_addr = 8'h00;
    endtask

    // Read takes two cycles: data phase, then a turnaround so the block has
    // released the bus before anything else drives it.
    task automatic rd_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        bif.bus_addr = a;
        bif.bus_we   = 1'b0;
        step();
        rd = bus_data;
        chk(tag, rd, exp);
        bif.bus_addr = 8'h00;
        step();
    endtask

    function automatic logic [7:0] irq();
        return {7'b0, bif.irq_raise};
    endfunction

    function automatic logic [7:0] ack();
        return {4'b0, bif.src_ack};
    endfunction

    initial begin
        bif.bus_addr = 8'h00;
        bif.bus_we   = 1'b0;
        bif.src_in   = 4'b0000;
        bif.irq_ack  = 1'b0;

        // ---------------- reset state ----------------
        step(); step(); step();
        chk("rst_irq", irq(), 8'h00);
        chk("rst_ack", ack(), 8'h00);
        chk("rst_busz", bus_data, 8'hFF);
        rst_n = 1'b1;
        step();
        rd_chk("rst_pend",   BASE + 8'd0, 8'h00);
        rd_chk("rst_mask",   BASE + 8'd1, 8'h00);
        rd_chk("rst_vector", BASE + 8'd2, 8'h00);
        rd_chk("rst_mode",   BASE + 8'd3, 8'h0F);
        chk("busz_after_rd", bus_data, 8'hFF);
        chk("idle_irq", irq(), 8'h00);

        // ---------------- single edge source ----------------
        bus_wr(BASE + 8'd1, 8'h0F);
        rd_chk("mask_wr", BASE + 8'd1, 8'h0F);
        bif.src_in = 4'b0100;
        step();
        bif.src_in = 4'b0000;
        chk("e2_irq_n1", irq(), 8'h00);
        step();
        chk("e2_irq_n2", irq(), 8'h01);
        step(); step();
        chk("e2_irq_hold", irq(), 8'h01);
        bif.irq_ack = 1'b1;
        step();
        bif.irq_ack = 1'b0;
        chk("e2_srcack", ack(), 8'h04);
        chk("e2_irq_gap", irq(), 8'h00);
        step();
        chk("e2_srcack_1cyc", ack(), 8'h00);
        rd_chk("e2_vector", BASE + 8'd2, 8'h82);
        rd_chk("e2_pend",   BASE + 8'd0, 8'h00);

        // ---------------- two simultaneous edges ----------------
        bif.src_in = 4'b1010;
        step();
        bif.src_in = 4'b0000;
        step();
        chk("dual_irq", irq(), 8'h01);
        rd_chk("dual_pend", BASE + 8'd0, 8'h0A);
        bif.irq_ack = 1'b1;
        step();
        bif.irq_ack = 1'b0;
        chk("dual_ack1", ack(), 8'h02);
        chk("dual_gap_m1", irq(), 8'h00);
        step();
        chk("dual_gap_m2", irq(), 8'h00);
        step();
        chk("dual_reraise_m3", irq(), 8'h01);
        rd_chk("dual_vec1", BASE + 8'd2, 8'h81);
        bif.irq_ack = 1'b1;
        step();
        bif.irq_ack = 1'b0;
        chk("dual_ack2", ack(), 8'h08);
        step(); step();
        rd_chk("dual_vec2", BASE + 8'd2, 8'h83);
        rd_chk("dual_pend_clr", BASE + 8'd0, 8'h00);
        chk("dual_idle", irq(), 8'h00);

        // ---------------- level mode ----------------
        bus_wr(BASE + 8'd3, 8'h00);
        bus_wr(BASE + 8'd1, 8'h01);
        bif.src_in = 4'b0001;
        step(); step();
        chk("lvl_irq", irq(), 8'h01);
        bif.irq_ack = 1'b1;
        step();
        bif.irq_ack = 1'b0;
        chk("lvl_ack1", ack(), 8'h01);
        step();
        chk("lvl_gap", irq(), 8'h00);
        step();
        chk("lvl_reraise_m3", irq(), 8'h01);
        bif.irq_ack = 1'b1;
        step();
        bif.irq_ack = 1'b0;
        chk("lvl_ack2", ack(), 8'h01);
        bif.src_in = 4'b0000;
        step(); step();
        chk("lvl_no_reraise_m3", irq(), 8'h00);
        step();
        chk("lvl_no_reraise_m4", irq(), 8'h00);
        rd_chk("lvl_vector", BASE + 8'd2, 8'h80);

        // ---------------- set beats W1C, mask drop in RAISED ----------------
        bus_wr(BASE + 8'd3, 8'h0F);
        bus_wr(BASE + 8'd1, 8'h0F);
        bif.bus_addr = BASE;
        bif.bus_we   = 1'b1;
        drv          = 8'h01;
        drv_en       = 1'b1;
        bif.src_in   = 4'b0001;
        step();
        bif.bus_we   = 1'b0;
        drv_en       = 1'b0;
        bif.bus_addr = 8'h00;
        bif.src_in   = 4'b0000;
        rd_chk("setwins_pend", BASE + 8'd0, 8'h01);
        chk("setwins_irq", irq(), 8'h01);
        bus_wr(BASE + 8'd1, 8'h00);
        step();
        chk("maskdrop_irq", irq(), 8'h00);
        step();
        chk("maskdrop_stay", irq(), 8'h00);
        rd_chk("maskdrop_vec", BASE + 8'd2, 8'h80);
        bus_wr(BASE + 8'd0, 8'h01);
        rd_chk("w1c_pend", BASE + 8'd0, 8'h00);

        // ---------------- async reset while RAISED ----------------
        bus_wr(BASE + 8'd1, 8'h0F);
        bif.src_in = 4'b0101;
        step();
        bif.src_in = 4'b0000;
        step();
        chk("pre_rst_irq", irq(), 8'h01);
        rd_chk("pre_rst_pend", BASE + 8'd0, 8'h05);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_irq", irq(), 8'h00);
        chk("async_rst_ack", ack(), 8'h00);
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_ack", ack(), 8'h00);
            chk("post_rst_irq", irq(), 8'h00);
        end
        rd_chk("post_rst_pend", BASE + 8'd0, 8'h00);
        rd_chk("post_rst_mask", BASE + 8'd1, 8'h00);

        // ---------------- ack outside RAISED ----------------
        bif.irq_ack = 1'b1;
        step();
        bif.irq_ack = 1'b0;
        chk("stray_ack", ack(), 8'h00);
        step();
        chk("stray_ack_irq", irq(), 8'h00);
        rd_chk("stray_vec", BASE + 8'd2, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
